// File: rtl/video_in_pkg.sv
// Shared definitions for the video_in capture path: frame geometry defaults,
// Wishbone cycle-type codes and the store FSM state encoding.
// Latency/backpressure: n/a (declarations only).
package video_in_pkg;

    localparam int P_WIDTH_DEF  = 640;
    localparam int P_HEIGHT_DEF = 480;

    localparam logic [2:0] WB_CTI_INCR = 3'b010;
    localparam logic [2:0] WB_CTI_EOB  = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } store_state_t;

    // Counter width helper that never collapses to a zero-width vector.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/video_in_store.sv
// Purpose: drains the 32-bit pixel FIFO into a double-buffered frame store via Wishbone burst writes.
// Latency: a burst starts 1 cycle after WAIT sees p_BURST words; one word per acked beat; frame_done 1 cycle after last ack.
// Backpressure: slave wait states (no ack) stall the beat with adr/data held; nothing is popped without an ack.
//
// Ports:
//   clk, RST (sync, active high)       enable: capture on / stop at next burst boundary
//   buf0_addr, buf1_addr               frame buffer byte base addresses
//   fifo_data, fifo_level, fifo_r_e    FWFT pixel FIFO head, fill level, pop
//   wb_*                               Wishbone master (write-only, incrementing bursts)
//   cur_buf, frame_done                buffer being filled, end-of-frame pulse
//   err_cnt                            saturating error count (only with VIDEO_IN_STORE_ERR_EN)
// Build option: define VIDEO_IN_STORE_ERR_EN to end a burst on wb_err_i and retry from the failed word.
module video_in_store
    import video_in_pkg::*;
#(
    parameter int p_WIDTH  = P_WIDTH_DEF,
    parameter int p_HEIGHT = P_HEIGHT_DEF,
    parameter int p_BURST  = 8,
    parameter int p_LVL_W  = 6
) (
    input  logic               clk,
    input  logic               RST,
    input  logic               enable,
    input  logic [31:0]        buf0_addr,
    input  logic [31:0]        buf1_addr,
    input  logic [31:0]        fifo_data,
    input  logic [p_LVL_W-1:0] fifo_level,
    output logic               fifo_r_e,
    output logic [31:0]        wb_adr_o,
    output logic [31:0]        wb_dat_o,
    output logic [3:0]         wb_sel_o,
    output logic               wb_we_o,
    output logic               wb_cyc_o,
    output logic               wb_stb_o,
    output logic [2:0]         wb_cti_o,
    input  logic               wb_ack_i,
    input  logic               wb_err_i,
    output logic               cur_buf,
`ifdef VIDEO_IN_STORE_ERR_EN
    output logic [7:0]         err_cnt,
`endif
    output logic               frame_done
);

    localparam int WORDS = p_WIDTH * p_HEIGHT / 4;
    localparam int WC_W  = clog2_min1(WORDS);
    localparam int BT_W  = clog2_min1(p_BURST);

    localparam logic [WC_W-1:0]    LAST_WORD = WC_W'(WORDS - 1);
    localparam logic [BT_W-1:0]    LAST_BEAT = BT_W'(p_BURST - 1);
    localparam logic [p_LVL_W-1:0] BURST_LVL = p_LVL_W'(p_BURST);

    store_state_t    state_q, state_d;
    logic [WC_W-1:0] word_cnt_q, word_cnt_d;
    logic [BT_W-1:0] beat_q, beat_d;
    logic            cur_buf_q, cur_buf_d;
    logic [31:0]     base_q, base_d;
    logic            frame_done_q, frame_done_d;
    logic            in_burst;
    logic            beat_ack;

`ifdef VIDEO_IN_STORE_ERR_EN
    logic [7:0]      err_cnt_q, err_cnt_d;
`else
    logic            unused_err;
    assign unused_err = wb_err_i;
`endif

    assign in_burst = (state_q == BURST);

    // A beat completes only on a clean ack; an errored beat is neither popped nor counted.
`ifdef VIDEO_IN_STORE_ERR_EN
    assign beat_ack = in_burst & wb_ack_i & ~wb_err_i;
`else
    assign beat_ack = in_burst & wb_ack_i;
`endif

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q      <= IDLE;
            word_cnt_q   <= '0;
            beat_q       <= '0;
            cur_buf_q    <= 1'b0;
            base_q       <= 32'h0;
            frame_done_q <= 1'b0;
`ifdef VIDEO_IN_STORE_ERR_EN
            err_cnt_q    <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            beat_q       <= beat_d;
            cur_buf_q    <= cur_buf_d;
            base_q       <= base_d;
            frame_done_q <= frame_done_d;
`ifdef VIDEO_IN_STORE_ERR_EN
            err_cnt_q    <= err_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        beat_d       = beat_q;
        cur_buf_d    = cur_buf_q;
        base_d       = base_q;
        frame_done_d = 1'b0;
`ifdef VIDEO_IN_STORE_ERR_EN
        err_cnt_d    = err_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!enable) begin
                    // Stopping restarts the next capture at the top of buffer 0.
                    state_d    = IDLE;
                    word_cnt_d = '0;
                    cur_buf_d  = 1'b0;
                end else if (fifo_level >= BURST_LVL) begin
                    // Base is latched per burst, so a base change mid-frame takes effect
                    // at the next burst boundary.
                    state_d = BURST;
                    beat_d  = '0;
                    base_d  = cur_buf_q ? buf1_addr : buf0_addr;
                end
            end
            BURST: begin
`ifdef VIDEO_IN_STORE_ERR_EN
                if (wb_err_i) begin
                    // word_cnt is left alone so the retry starts at the failed word.
                    state_d = WAIT;
                    beat_d  = '0;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end else
`endif
                if (wb_ack_i) begin
                    beat_d     = beat_q + 1'b1;
                    word_cnt_d = (word_cnt_q == LAST_WORD) ? '0 : word_cnt_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = WAIT;
                        beat_d  = '0;
                        if (word_cnt_q == LAST_WORD) begin
                            cur_buf_d    = ~cur_buf_q;
                            frame_done_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are qualified by the registered BURST state so the bus is quiet outside bursts.
    assign wb_cyc_o   = in_burst;
    assign wb_stb_o   = in_burst;
    assign wb_we_o    = 1'b1;
    assign wb_sel_o   = 4'hF;
    assign wb_adr_o   = in_burst ? (base_q + 32'({word_cnt_q, 2'b00})) : 32'h0;
    assign wb_dat_o   = in_burst ? fifo_data : 32'h0;
    assign wb_cti_o   = !in_burst ? 3'b000 :
                        (beat_q == LAST_BEAT) ? WB_CTI_EOB : WB_CTI_INCR;
    assign fifo_r_e   = beat_ack;
    assign cur_buf    = cur_buf_q;
    assign frame_done = frame_done_q;
`ifdef VIDEO_IN_STORE_ERR_EN
    assign err_cnt    = err_cnt_q;
`endif

endmodule

// File: tb/tb_video_in_store.sv
module tb_video_in_store;

    localparam logic [31:0] B0 = 32'h1000_0000;
    localparam logic [31:0] B1 = 32'h2000_0000;

    logic        clk = 1'b0;
    logic        RST;
    logic        enable;
    logic [31:0] buf0_addr;
    logic [31:0] buf1_addr;
    logic [31:0] fifo_data;
    logic [5:0]  fifo_level;
    logic        fifo_r_e;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [2:0]  wb_cti_o;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        cur_buf;
    logic        frame_done;
`ifdef VIDEO_IN_STORE_ERR_EN
    logic [7:0]  err_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int ncyc;
    int pops;

    always #5 clk = ~clk;

    video_in_store #(
        .p_WIDTH (16),
        .p_HEIGHT(4),
        .p_BURST (8),
        .p_LVL_W (6)
    ) dut (
        .clk       (clk),
        .RST       (RST),
        .enable    (enable),
        .buf0_addr (buf0_addr),
        .buf1_addr (buf1_addr),
        .fifo_data (fifo_data),
        .fifo_level(fifo_level),
        .fifo_r_e  (fifo_r_e),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_sel_o  (wb_sel_o),
        .wb_we_o   (wb_we_o),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_cti_o  (wb_cti_o),
        .wb_ack_i  (wb_ack_i),
        .wb_err_i  (wb_err_i),
        .cur_buf   (cur_buf),
`ifdef VIDEO_IN_STORE_ERR_EN
        .err_cnt   (err_cnt),
`endif
        .frame_done(frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Bounded wait for the bus cycle to open.
    task automatic wait_cyc(input string tag);
        int n = 0;
        while (!wb_cyc_o && n < 10) begin
            tick();
            n++;
        end
        chk(tag, 32'(wb_cyc_o), 32'd1);
    endtask

    // Drives one 8-beat burst as the slave; entered with cyc already high.
    task automatic run_burst(input string tag, input logic [31:0] base, input int word0,
                             input int waits, input int drop_beat, input logic exp_done,
                             output int cyc_cycles);
        logic [31:0] a;
        logic [31:0] d;
        int          np;
        cyc_cycles = 0;
        np = 0;
        for (int b = 0; b < 8; b++) begin
            a = base + 32'((word0 + b) * 4);
            d = 32'hD000_0000 + 32'(word0 + b);
            fifo_data = d;
            for (int w = 0; w < waits; w++) begin
                wb_ack_i = 1'b0;
                #1;
                chk({tag, "_wait_adr"}, wb_adr_o, a);
                chk({tag, "_wait_dat"}, wb_dat_o, d);
                chk({tag, "_wait_pop"}, 32'(fifo_r_e), 32'd0);
                if (wb_cyc_o) cyc_cycles++;
                tick();
            end
            wb_ack_i = 1'b1;
            if (b == drop_beat) enable = 1'b0;
            #1;
            chk({tag, "_adr"}, wb_adr_o, a);
            chk({tag, "_dat"}, wb_dat_o, d);
            chk({tag, "_cti"}, 32'(wb_cti_o), (b == 7) ? 32'd7 : 32'd2);
            chk({tag, "_stb_we"}, {30'd0, wb_stb_o, wb_we_o}, 32'd3);
            chk({tag, "_pop"}, 32'(fifo_r_e), 32'd1);
            if (wb_cyc_o) cyc_cycles++;
            if (fifo_r_e) np++;
            tick();
        end
        wb_ack_i   = 1'b0;
        fifo_level = 6'd0;
        chk({tag, "_pops"}, 32'(np), 32'd8);
        chk({tag, "_cyc_end"}, 32'(wb_cyc_o), 32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'(exp_done));
    endtask

    initial begin
        RST        = 1'b1;
        enable     = 1'b0;
        buf0_addr  = B0;
        buf1_addr  = B1;
        fifo_data  = 32'h0;
        fifo_level = 6'd0;
        wb_ack_i   = 1'b0;
        wb_err_i   = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
        chk("rst_adr", wb_adr_o, 32'h0);
        chk("rst_cti", 32'(wb_cti_o), 32'd0);
        chk("rst_pop", 32'(fifo_r_e), 32'd0);
        chk("rst_cur_buf", 32'(cur_buf), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_sel", 32'(wb_sel_o), 32'hF);
`ifdef VIDEO_IN_STORE_ERR_EN
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif

        // Zero-wait burst, frame 1 words 0..7 in buffer 0
        RST        = 1'b0;
        enable     = 1'b1;
        fifo_level = 6'd8;
        wait_cyc("t1_start");
        run_burst("t1", B0, 0, 0, -1, 1'b0, ncyc);
        chk("t1_cycles", 32'(ncyc), 32'd8);

        // Level 7 must not start a burst; level 8 starts one a cycle later
        fifo_level = 6'd7;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_lvl7_cyc", 32'(wb_cyc_o), 32'd0);
        end
        fifo_level = 6'd8;
        tick();
        chk("t2_lvl8_cyc", 32'(wb_cyc_o), 32'd1);

        // Two wait states per beat, words 8..15 close frame 1
        run_burst("t2", B0, 8, 2, -1, 1'b1, ncyc);
        chk("t2_cycles", 32'(ncyc), 32'd24);
        chk("t2_cur_buf", 32'(cur_buf), 32'd1);
        tick();
        chk("t2_done_pulse", 32'(frame_done), 32'd0);

        // Frame 2 lands in buffer 1
        fifo_level = 6'd8;
        wait_cyc("t3a_start");
        run_burst("t3a", B1, 0, 0, -1, 1'b0, ncyc);
        fifo_level = 6'd8;
        wait_cyc("t3b_start");
        run_burst("t3b", B1, 8, 1, -1, 1'b1, ncyc);
        chk("t3_cur_buf", 32'(cur_buf), 32'd0);

        // Frame 3 returns to buffer 0
        fifo_level = 6'd8;
        wait_cyc("t4a_start");
        run_burst("t4a", B0, 0, 0, -1, 1'b0, ncyc);
        fifo_level = 6'd8;
        wait_cyc("t4b_start");
        run_burst("t4b", B0, 8, 0, -1, 1'b1, ncyc);
        chk("t4_cur_buf", 32'(cur_buf), 32'd1);

        // enable dropped on beat 3 of a buffer-1 burst: burst completes, then stop
        fifo_level = 6'd8;
        wait_cyc("t5_start");
        run_burst("t5", B1, 0, 0, 3, 1'b0, ncyc);
        fifo_level = 6'd8;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_idle_cyc", 32'(wb_cyc_o), 32'd0);
        end
        chk("t5_cur_buf", 32'(cur_buf), 32'd0);
        enable = 1'b1;
        wait_cyc("t5_restart");
        run_burst("t5r", B0, 0, 0, -1, 1'b0, ncyc);

        // Reset in the middle of a burst
        fifo_level = 6'd8;
        wait_cyc("t6_start");
        fifo_data = 32'hD000_0008;
        wb_ack_i  = 1'b1;
        tick();
        wb_ack_i  = 1'b1;
        #1;
        chk("t6_adr_beat1", wb_adr_o, B0 + 32'h24);
        tick();
        RST      = 1'b1;
        wb_ack_i = 1'b0;
        tick();
        RST      = 1'b0;
        wb_ack_i = 1'b1;
        #1;
        chk("t6_cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
        chk("t6_pop", 32'(fifo_r_e), 32'd0);
        chk("t6_cur_buf", 32'(cur_buf), 32'd0);
        wb_ack_i   = 1'b0;
        fifo_level = 6'd0;

`ifdef VIDEO_IN_STORE_ERR_EN
        // Error on beat 5: five pops, burst ends, retry from word 5
        fifo_level = 6'd8;
        wait_cyc("t7_start");
        pops = 0;
        for (int b = 0; b < 5; b++) begin
            fifo_data = 32'hD000_0000 + 32'(b);
            wb_ack_i  = 1'b1;
            #1;
            if (fifo_r_e) pops++;
            tick();
        end
        wb_ack_i = 1'b0;
        wb_err_i = 1'b1;
        #1;
        chk("t7_err_adr", wb_adr_o, B0 + 32'h14);
        chk("t7_err_pop", 32'(fifo_r_e), 32'd0);
        tick();
        wb_err_i = 1'b0;
        chk("t7_pops", 32'(pops), 32'd5);
        chk("t7_cyc_end", 32'(wb_cyc_o), 32'd0);
        chk("t7_err_cnt", 32'(err_cnt), 32'd1);
        tick();
        chk("t7_retry_cyc", 32'(wb_cyc_o), 32'd1);
        run_burst("t7r", B0, 5, 0, -1, 1'b0, ncyc);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
